// File: rtl/bus_arbiter_if.sv
// Bus bundle between the pipeline (ibus/dbus), the arbiter and the external memory port.
// The master modport is the arbiter's view; slave is the surrounding pipeline/memory.
interface bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  ibus_en;
  logic [ADDR_W-1:0]     ibus_addr;
  logic [DATA_W-1:0]     ibus_rdata;
  logic                  ibus_stall;

  logic                  dbus_en;
  logic [ADDR_W-1:0]     dbus_addr;
  logic [DATA_W/8-1:0]   dbus_wen;
  logic [DATA_W-1:0]     dbus_wdata;
  logic [DATA_W-1:0]     dbus_rdata;
  logic                  dbus_stall;

  logic                  mem_req;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_wen;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    input  ibus_en, ibus_addr,
    output ibus_rdata, ibus_stall,
    input  dbus_en, dbus_addr, dbus_wen, dbus_wdata,
    output dbus_rdata, dbus_stall,
    output mem_req, mem_addr, mem_wen, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    output ibus_en, ibus_addr,
    input  ibus_rdata, ibus_stall,
    output dbus_en, dbus_addr, dbus_wen, dbus_wdata,
    input  dbus_rdata, dbus_stall,
    input  mem_req, mem_addr, mem_wen, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// Shares one memory port between ibus and dbus (dbus first), one transaction in flight.
// state   | meaning
// IDLE    | no transaction; pick dbus, then ibus
// REQ     | mem_req high, request registers held until mem_gnt
// RESP    | waiting for mem_rvalid, then hand result to owner
module bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           hold,
  bus_arbiter_if.master  bus
);
  localparam int BE_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;   // 1 = dbus, 0 = ibus
  logic              abort_q, abort_d;
  logic              i_done_q, i_done_d;
  logic              d_done_q, d_done_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BE_W-1:0]   wen_q, wen_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;
  logic              owner_en;

  assign owner_en = owner_q ? bus.dbus_en : bus.ibus_en;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    abort_d  = abort_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    wdata_d  = wdata_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    // a completed result lives until a non-held edge consumes it
    i_done_d = i_done_q & hold;
    d_done_d = d_done_q & hold;

    case (state_q)
      S_IDLE: begin
        if (bus.dbus_en && !d_done_q) begin
          addr_d  = bus.dbus_addr;
          wen_d   = bus.dbus_wen;
          wdata_d = bus.dbus_wdata;
          owner_d = 1'b1;
          abort_d = 1'b0;
          state_d = S_REQ;
        end else if (bus.ibus_en && !i_done_q) begin
          addr_d  = bus.ibus_addr;
          wen_d   = '0;
          wdata_d = '0;
          owner_d = 1'b0;
          abort_d = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!owner_en) abort_d = 1'b1;
        if (bus.mem_gnt) state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.mem_rvalid) begin
          state_d = S_IDLE;
          // an owner that dropped its request mid-flight gets nothing back
          if (!abort_q && owner_en) begin
            if (owner_q) begin
              drdata_d = bus.mem_rdata;
              d_done_d = 1'b1;
            end else begin
              irdata_d = bus.mem_rdata;
              i_done_d = 1'b1;
            end
          end
        end else if (!owner_en) begin
          abort_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      abort_q  <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
      addr_q   <= '0;
      wen_q    <= '0;
      wdata_q  <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      abort_q  <= abort_d;
      i_done_q <= i_done_d;
      d_done_q <= d_done_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
    end
  end

  assign bus.mem_req    = (state_q == S_REQ);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wen    = wen_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.ibus_rdata = irdata_q;
  assign bus.dbus_rdata = drdata_q;
  assign bus.ibus_stall = bus.ibus_en & ~i_done_q;
  assign bus.dbus_stall = bus.dbus_en & ~d_done_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: each task plays one scenario cycle by cycle
// against hand-computed expectations.
module tb_bus_arbiter;
  logic clk;
  logic resetn;
  logic hold;
  int   total;
  int   bad;

  bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .hold   (hold),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0h exp=0", bus.mem_req); end
    total++; if (bus.mem_addr !== 32'h0) begin bad++; $display("FAIL rst_mem_addr got=%0h exp=0", bus.mem_addr); end
    total++; if (bus.ibus_rdata !== 32'h0) begin bad++; $display("FAIL rst_ibus_rdata got=%0h exp=0", bus.ibus_rdata); end
    total++; if (bus.dbus_rdata !== 32'h0) begin bad++; $display("FAIL rst_dbus_rdata got=%0h exp=0", bus.dbus_rdata); end
    bus.ibus_en = 1'b1;
    #1;
    total++; if (bus.ibus_stall !== 1'b1) begin bad++; $display("FAIL rst_ibus_stall got=%0h exp=1", bus.ibus_stall); end
    bus.ibus_en = 1'b0;
    step();
    step();
    resetn = 1'b1;
    step();
    #2;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_idle_req got=%0h exp=0", bus.mem_req); end
  endtask

  task automatic test_single_read();
    step();                                    // cycle 0
    bus.ibus_en = 1'b1; bus.ibus_addr = 32'hBFC0_0000;
    #2;
    total++; if (bus.ibus_stall !== 1'b1) begin bad++; $display("FAIL sr_stall_c0 got=%0h exp=1", bus.ibus_stall); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL sr_req_c0 got=%0h exp=0", bus.mem_req); end
    step();                                    // cycle 1
    bus.mem_gnt = 1'b1;
    #2;
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL sr_req_c1 got=%0h exp=1", bus.mem_req); end
    total++; if (bus.mem_addr !== 32'hBFC0_0000) begin bad++; $display("FAIL sr_addr got=%0h exp=bfc00000", bus.mem_addr); end
    total++; if (bus.mem_wen !== 4'h0) begin bad++; $display("FAIL sr_wen got=%0h exp=0", bus.mem_wen); end
    step();                                    // cycle 2
    bus.mem_gnt = 1'b0;
    #2;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL sr_req_c2 got=%0h exp=0", bus.mem_req); end
    total++; if (bus.ibus_stall !== 1'b1) begin bad++; $display("FAIL sr_stall_c2 got=%0h exp=1", bus.ibus_stall); end
    step();                                    // cycle 3
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h3C1A_0001;
    #2;
    total++; if (bus.ibus_stall !== 1'b1) begin bad++; $display("FAIL sr_stall_c3 got=%0h exp=1", bus.ibus_stall); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL sr_req_c3 got=%0h exp=0", bus.mem_req); end
    step();                                    // cycle 4
    bus.mem_rvalid = 1'b0;
    #2;
    total++; if (bus.ibus_stall !== 1'b0) begin bad++; $display("FAIL sr_stall_c4 got=%0h exp=0", bus.ibus_stall); end
    total++; if (bus.ibus_rdata !== 32'h3C1A_0001) begin bad++; $display("FAIL sr_rdata got=%0h exp=3c1a0001", bus.ibus_rdata); end
    bus.ibus_en = 1'b0;
    step();
    #2;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL sr_req_c5 got=%0h exp=0", bus.mem_req); end
  endtask

  task automatic test_collision();
    step();                                    // cycle 0
    bus.ibus_en = 1'b1; bus.ibus_addr = 32'hBFC0_0004;
    bus.dbus_en = 1'b1; bus.dbus_addr = 32'h8000_1000; bus.dbus_wen = 4'h0;
    #2;
    total++; if (bus.dbus_stall !== 1'b1) begin bad++; $display("FAIL col_dstall_c0 got=%0h exp=1", bus.dbus_stall); end
    step();                                    // cycle 1
    bus.mem_gnt = 1'b1;
    #2;
    total++; if (bus.mem_addr !== 32'h8000_1000) begin bad++; $display("FAIL col_first_addr got=%0h exp=80001000", bus.mem_addr); end
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL col_req_c1 got=%0h exp=1", bus.mem_req); end
    step();                                    // cycle 2
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1111_2222;
    #2;
    total++; if (bus.dbus_stall !== 1'b1) begin bad++; $display("FAIL col_dstall_c2 got=%0h exp=1", bus.dbus_stall); end
    step();                                    // cycle 3
    bus.mem_rvalid = 1'b0;
    #2;
    total++; if (bus.dbus_stall !== 1'b0) begin bad++; $display("FAIL col_dstall_c3 got=%0h exp=0", bus.dbus_stall); end
    total++; if (bus.dbus_rdata !== 32'h1111_2222) begin bad++; $display("FAIL col_drdata got=%0h exp=11112222", bus.dbus_rdata); end
    total++; if (bus.ibus_stall !== 1'b1) begin bad++; $display("FAIL col_istall_c3 got=%0h exp=1", bus.ibus_stall); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL col_req_c3 got=%0h exp=0", bus.mem_req); end
    bus.dbus_en = 1'b0;
    step();                                    // cycle 4
    bus.mem_gnt = 1'b1;
    #2;
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL col_req_c4 got=%0h exp=1", bus.mem_req); end
    total++; if (bus.mem_addr !== 32'hBFC0_0004) begin bad++; $display("FAIL col_second_addr got=%0h exp=bfc00004", bus.mem_addr); end
    step();                                    // cycle 5
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h3333_4444;
    #2;
    total++; if (bus.ibus_stall !== 1'b1) begin bad++; $display("FAIL col_istall_c5 got=%0h exp=1", bus.ibus_stall); end
    step();                                    // cycle 6
    bus.mem_rvalid = 1'b0;
    #2;
    total++; if (bus.ibus_stall !== 1'b0) begin bad++; $display("FAIL col_istall_c6 got=%0h exp=0", bus.ibus_stall); end
    total++; if (bus.ibus_rdata !== 32'h3333_4444) begin bad++; $display("FAIL col_irdata got=%0h exp=33334444", bus.ibus_rdata); end
    total++; if (bus.dbus_rdata !== 32'h1111_2222) begin bad++; $display("FAIL col_drdata_keep got=%0h exp=11112222", bus.dbus_rdata); end
    bus.ibus_en = 1'b0;
  endtask

  task automatic test_store();
    step();                                    // cycle 0
    bus.dbus_en = 1'b1; bus.dbus_addr = 32'h8000_0002;
    bus.dbus_wen = 4'b0011; bus.dbus_wdata = 32'hDEAD_BEEF;
    step();                                    // cycle 1: inputs change, request must not
    bus.dbus_wdata = 32'h0BAD_0BAD; bus.dbus_wen = 4'b1100; bus.dbus_addr = 32'h8000_0010;
    for (int i = 0; i < 4; i++) begin
      bus.mem_gnt = (i == 3);
      #2;
      total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL st_req[%0d] got=%0h exp=1", i, bus.mem_req); end
      total++; if (bus.mem_wen !== 4'b0011) begin bad++; $display("FAIL st_wen[%0d] got=%0h exp=3", i, bus.mem_wen); end
      total++; if (bus.mem_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL st_wdata[%0d] got=%0h exp=deadbeef", i, bus.mem_wdata); end
      total++; if (bus.mem_addr !== 32'h8000_0002) begin bad++; $display("FAIL st_addr[%0d] got=%0h exp=80000002", i, bus.mem_addr); end
      step();
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5A5A_5A5A;
    #2;
    total++; if (bus.dbus_stall !== 1'b1) begin bad++; $display("FAIL st_stall_rv got=%0h exp=1", bus.dbus_stall); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL st_req_rv got=%0h exp=0", bus.mem_req); end
    step();
    bus.mem_rvalid = 1'b0;
    #2;
    total++; if (bus.dbus_stall !== 1'b0) begin bad++; $display("FAIL st_stall_done got=%0h exp=0", bus.dbus_stall); end
    bus.dbus_en = 1'b0; bus.dbus_wen = 4'h0;
  endtask

  task automatic test_hold();
    step();                                    // cycle 0
    bus.ibus_en = 1'b1; bus.ibus_addr = 32'hBFC0_0008;
    step();                                    // cycle 1
    bus.mem_gnt = 1'b1;
    step();                                    // cycle 2
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAAAA_5555;
    step();                                    // cycle 3
    bus.mem_rvalid = 1'b0; hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      total++; if (bus.ibus_stall !== 1'b0) begin bad++; $display("FAIL hold_stall[%0d] got=%0h exp=0", i, bus.ibus_stall); end
      total++; if (bus.ibus_rdata !== 32'hAAAA_5555) begin bad++; $display("FAIL hold_rdata[%0d] got=%0h exp=aaaa5555", i, bus.ibus_rdata); end
      total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL hold_req[%0d] got=%0h exp=0", i, bus.mem_req); end
      step();
    end
    hold = 1'b0; bus.ibus_addr = 32'hBFC0_000C;     // cycle 7: result consumed
    #2;
    total++; if (bus.ibus_stall !== 1'b0) begin bad++; $display("FAIL hold_rel_stall got=%0h exp=0", bus.ibus_stall); end
    step();                                    // cycle 8
    #2;
    total++; if (bus.ibus_stall !== 1'b1) begin bad++; $display("FAIL hold_next_stall got=%0h exp=1", bus.ibus_stall); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL hold_next_req_c8 got=%0h exp=0", bus.mem_req); end
    step();                                    // cycle 9
    bus.mem_gnt = 1'b1;
    #2;
    total++; if (bus.mem_req !== 1'b1) begin bad++; $display("FAIL hold_next_req got=%0h exp=1", bus.mem_req); end
    total++; if (bus.mem_addr !== 32'hBFC0_000C) begin bad++; $display("FAIL hold_next_addr got=%0h exp=bfc0000c", bus.mem_addr); end
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
    step();
    bus.mem_rvalid = 1'b0;
    #2;
    total++; if (bus.ibus_rdata !== 32'h1234_5678) begin bad++; $display("FAIL hold_next_rdata got=%0h exp=12345678", bus.ibus_rdata); end
    bus.ibus_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();                                    // cycle 0
    bus.dbus_en = 1'b1; bus.dbus_addr = 32'h8000_2000; bus.dbus_wen = 4'h0;
    step();                                    // cycle 1
    bus.mem_gnt = 1'b1;
    step();                                    // cycle 2: in RESP
    bus.mem_gnt = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rm_req got=%0h exp=0", bus.mem_req); end
    total++; if (bus.dbus_rdata !== 32'h0) begin bad++; $display("FAIL rm_drdata got=%0h exp=0", bus.dbus_rdata); end
    total++; if (bus.ibus_rdata !== 32'h0) begin bad++; $display("FAIL rm_irdata got=%0h exp=0", bus.ibus_rdata); end
    total++; if (bus.dbus_stall !== 1'b1) begin bad++; $display("FAIL rm_stall got=%0h exp=1", bus.dbus_stall); end
    step();
    resetn = 1'b1; bus.dbus_en = 1'b0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h7777_7777;
    step();
    bus.mem_rvalid = 1'b0;
    #2;
    total++; if (bus.dbus_rdata !== 32'h0) begin bad++; $display("FAIL rm_late_rdata got=%0h exp=0", bus.dbus_rdata); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rm_late_req got=%0h exp=0", bus.mem_req); end
    bus.dbus_en = 1'b1;
    #1;
    total++; if (bus.dbus_stall !== 1'b1) begin bad++; $display("FAIL rm_no_done got=%0h exp=1", bus.dbus_stall); end
    bus.dbus_en = 1'b0;
    step();
    #2;
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL rm_idle_req got=%0h exp=0", bus.mem_req); end
  endtask

  task automatic test_abandon();
    step();                                    // cycle 0
    bus.dbus_en = 1'b1; bus.dbus_addr = 32'h8000_3000; bus.dbus_wen = 4'h0;
    step();                                    // cycle 1
    bus.mem_gnt = 1'b1;
    step();                                    // cycle 2: RESP, requester gives up
    bus.mem_gnt = 1'b0; bus.dbus_en = 1'b0;
    #2;
    total++; if (bus.dbus_stall !== 1'b0) begin bad++; $display("FAIL ab_stall_off got=%0h exp=0", bus.dbus_stall); end
    step();                                    // cycle 3
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h9999_8888;
    step();                                    // cycle 4
    bus.mem_rvalid = 1'b0;
    #2;
    total++; if (bus.dbus_rdata !== 32'h0) begin bad++; $display("FAIL ab_rdata got=%0h exp=0", bus.dbus_rdata); end
    total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL ab_req got=%0h exp=0", bus.mem_req); end
    bus.dbus_en = 1'b1; bus.dbus_addr = 32'h8000_3004;
    #1;
    total++; if (bus.dbus_stall !== 1'b1) begin bad++; $display("FAIL ab_no_done got=%0h exp=1", bus.dbus_stall); end
    step();                                    // cycle 5
    bus.mem_gnt = 1'b1;
    #2;
    total++; if (bus.mem_addr !== 32'h8000_3004) begin bad++; $display("FAIL ab_new_addr got=%0h exp=80003004", bus.mem_addr); end
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    step();
    bus.mem_rvalid = 1'b0;
    #2;
    total++; if (bus.dbus_stall !== 1'b0) begin bad++; $display("FAIL ab_new_stall got=%0h exp=0", bus.dbus_stall); end
    total++; if (bus.dbus_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL ab_new_rdata got=%0h exp=cafef00d", bus.dbus_rdata); end
    bus.dbus_en = 1'b0;
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetn = 1'b0;
    hold   = 1'b0;
    bus.ibus_en = 1'b0; bus.ibus_addr = '0;
    bus.dbus_en = 1'b0; bus.dbus_addr = '0; bus.dbus_wen = '0; bus.dbus_wdata = '0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    test_reset();
    test_single_read();
    test_collision();
    test_store();
    test_hold();
    test_reset_mid();
    test_abandon();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares one external memory port between the instruction fetch bus (ibus) and the MEM-stage data bus (dbus) driven by MemAccess.
- Converts the single-cycle bus semantics the pipeline expects into a request/grant/response handshake on the memory side.
- Generates per-bus stall requests until each access completes.
- Supports one outstanding transaction at a time; dbus has fixed priority over ibus.

Parameters:
- ADDR_W, 32, address width of all buses.
- DATA_W, 32, data width of all buses; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- hold  in  1  pipeline frozen by a stall source other than this block; a completed result must be retained while high.
- ibus_en  in  1  instruction fetch request.
- ibus_addr  in  ADDR_W  fetch address.
- ibus_rdata  out  DATA_W  fetched instruction.
- ibus_stall  out  1  fetch not yet complete.
- dbus_en  in  1  data access request.
- dbus_addr  in  ADDR_W  data address.
- dbus_wen  in  DATA_W/8  byte write enables; 0 means read.
- dbus_wdata  in  DATA_W  store data.
- dbus_rdata  out  DATA_W  load data.
- dbus_stall  out  1  data access not yet complete.
- mem_req  out  1  request valid to memory.
- mem_addr  out  ADDR_W  request address.
- mem_wen  out  DATA_W/8  request byte enables.
- mem_wdata  out  DATA_W  request write data.
- mem_gnt  in  1  memory accepted the request this cycle.
- mem_rvalid  in  1  response valid (read data, or write acknowledge).
- mem_rdata  in  DATA_W  response data.

Behaviour:
- Reset (resetn=0), asynchronous and immediate:
  - state=IDLE, owner=none, i_done=d_done=0.
  - ibus_rdata=dbus_rdata=0, mem_req=0, mem_addr/mem_wen/mem_wdata=0.
  - Stall outputs follow the combinational rule below with done=0.
  - A transaction in flight when reset asserts is abandoned; a mem_rvalid arriving after reset releases is ignored in IDLE.
- Stall rules, combinational:
  - ibus_stall = ibus_en & ~i_done.
  - dbus_stall = dbus_en & ~d_done.
- FSM states:
  - IDLE:
    - If dbus_en & ~d_done: latch dbus addr/wen/wdata into request registers, owner=D, go to REQ.
    - Else if ibus_en & ~i_done: latch ibus_addr, wen=0, owner=I, go to REQ.
    - Else stay.
  - REQ:
    - mem_req=1; mem_addr/mem_wen/mem_wdata driven from the request registers, stable until grant.
    - On mem_gnt: go to RESP.
  - RESP:
    - mem_req=0.
    - On mem_rvalid: capture mem_rdata into the owner's rdata register; for writes, dbus_rdata is still loaded with mem_rdata, which is don't-care.
    - Set the owner's done flag and go to IDLE.
    - mem_rvalid in the same cycle as mem_gnt is not legal; the response is at least one cycle after the grant.
- Minimum latency: request seen in cycle 0, mem_req in cycle 1 with gnt, rvalid in cycle 2, stall low in cycle 3.
- Done flags:
  - x_done clears on a rising edge where hold=0 and x_done=1, i.e. the pipeline consumed the result.
  - While hold=1 it stays set, stall stays low and rdata stays stable.
  - A done flag set in cycle N is visible in cycle N+1 and clears no earlier than the end of N+1.
- Priority and simultaneity:
  - When both requests are pending in IDLE, dbus is served first and ibus_stall stays high throughout.
  - ibus is served on the next IDLE cycle.
  - A request deasserted while it is owner and in REQ/RESP still completes on memory; its result is discarded and its done flag is not set.
- Master inputs are sampled only at the IDLE→REQ transition; later changes do not affect the current transaction.
- No timeout. A hung memory stalls the pipeline indefinitely.

Test Plan:
- Single read: ibus_en=1, addr=0xBFC00000, gnt in cycle 1, rvalid with rdata=0x3C1A0001 in cycle 3 → mem_req high cycles 1 only, ibus_stall high cycles 0–3, low cycle 4, ibus_rdata=0x3C1A0001.
- Collision: ibus_en and dbus_en (read, 0x80001000) both rise in cycle 0; memory grants immediately and responds 1 cycle after grant → dbus transaction issued first and dbus_stall drops in cycle 3. ibus mem_req appears in cycle 4, and ibus_stall stays high until its own response.
- Store: dbus_wen=0b0011, wdata=0xDEADBEEF, addr=0x80000002 → mem_wen=0011 and mem_wdata=0xDEADBEEF held stable across 3 cycles of gnt=0; dbus_stall drops the cycle after rvalid.
- Hold: complete an ibus read, then hold=1 for 4 cycles → ibus_stall stays 0, ibus_rdata unchanged, and no new mem_req although ibus_en stays 1. hold=0 → i_done clears and a new fetch issues the next cycle.
- Reset mid-RESP: assert resetn=0 while waiting for rvalid → mem_req=0, state IDLE, rdata=0 immediately. A late rvalid after release causes no rdata change and no done flag.
- Abandoned request: drop dbus_en while in RESP → transaction completes on memory, dbus_rdata unchanged, d_done stays 0.
